// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, ALU, mux-select and sequencer state definitions for the multi-cycle CPU
package cpu_pkg;

    // Primary opcodes, IR[31:26]
    localparam logic [5:0] OP_ANDI  = 6'b000001;
    localparam logic [5:0] OP_ORI   = 6'b000010;
    localparam logic [5:0] OP_XORI  = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b000101;
    localparam logic [5:0] OP_SUBI  = 6'b000110;
    localparam logic [5:0] OP_LOAD  = 6'b001000;
    localparam logic [5:0] OP_STORE = 6'b001001;
    localparam logic [5:0] OP_BR    = 6'b001100;
    localparam logic [5:0] OP_BZ    = 6'b001101;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // ALU operation encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    // Datapath mux selects
    localparam logic PC_SRC_INC    = 1'b0;
    localparam logic PC_SRC_BRANCH = 1'b1;
    localparam logic ADDR_SEL_PC   = 1'b0;
    localparam logic ADDR_SEL_ALU  = 1'b1;
    localparam logic WB_SEL_ALU    = 1'b0;
    localparam logic WB_SEL_MEM    = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB,
        ST_BRANCH,
        ST_ERR
    } seq_state_e;

    // Registered datapath strobes and selects
    typedef struct packed {
        logic       pc_we;
        logic       pc_src;
        logic       ir_we;
        logic       addr_sel;
        logic       mem_rd;
        logic       mem_we;
        logic       reg_we;
        logic       wb_sel;
        logic [2:0] alu_op;
        logic       alu_b_imm;
        logic       flags_we;
    } ctrl_t;

    function automatic logic is_alu_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) ||
               (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    // Memory ops also use the adder for rs+imm, hence the ADD default
    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_XORI: return ALU_XOR;
            OP_SUBI: return ALU_SUB;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle control sequencer and memory-port arbiter for the CPU datapath
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_LAT   = 1,
    parameter int MAX_INSTR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ext_memwe,
    input  logic [5:0]  opcode,
    input  logic        zero,
    output logic        ext_grant,
    output logic        pc_clr,
    output logic        pc_we,
    output logic        pc_src,
    output logic        ir_we,
    output logic        addr_sel,
    output logic        mem_rd,
    output logic        mem_we,
    output logic        reg_we,
    output logic        wb_sel,
    output logic [2:0]  alu_op,
    output logic        alu_b_imm,
    output logic        flags_we,
    output logic        busy,
    output logic        err,
    output logic [15:0] retired
);

    localparam int               LAT_W       = 2;
    localparam logic [LAT_W-1:0] LAT_LAST    = LAT_W'(MEM_LAT - 1);
    localparam logic [15:0]      INSTR_LIMIT = 16'(MAX_INSTR);

    seq_state_e       state_q, state_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [15:0]      retired_q, retired_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             at_rest;
    logic             lat_done;
    logic             retire;

    // The loader's write enable is gated by ext_grant in the datapath; the
    // sequencer only decides ownership, so the request itself is not consumed here.
    logic unused_ext_memwe;
    assign unused_ext_memwe = ext_memwe;

    assign at_rest  = (state_q == ST_IDLE) || (state_q == ST_ERR);
    assign lat_done = (lat_cnt_q == LAT_LAST);

    // Next-state, latency counter and retire-count logic
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = '0;
        retire    = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (lat_done) state_d = ST_DECODE;
                else          lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
            ST_DECODE: begin
                case (opcode)
                    OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI,
                    OP_LOAD, OP_STORE: state_d = ST_EXEC;
                    OP_BR, OP_BZ:      state_d = ST_BRANCH;
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    default:           state_d = ST_ERR;
                endcase
            end
            ST_EXEC: begin
                if (is_alu_imm(opcode))      state_d = ST_WB;
                else if (opcode == OP_LOAD)  state_d = ST_MEM_RD;
                else                         state_d = ST_MEM_WR;
            end
            ST_MEM_RD: begin
                if (lat_done) state_d = ST_WB;
                else          lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
            ST_MEM_WR, ST_WB, ST_BRANCH: begin
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        retired_d = retired_q + 16'(retire);
        if (at_rest && start) retired_d = '0;

        // Instruction budget: the retirement that reaches the limit parks the CPU
        if (retire && (state_d == ST_FETCH) && (MAX_INSTR != 0) && (retired_d == INSTR_LIMIT))
            state_d = ST_IDLE;
    end

    // Strobes for the upcoming cycle, decoded from the next state. The opcode
    // and zero flag are already stable one cycle ahead (IR loads at the end of
    // FETCH, flags only change at the end of EXEC), so registering is exact.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            ST_FETCH: begin
                ctrl_d.addr_sel = ADDR_SEL_PC;
                ctrl_d.mem_rd   = 1'b1;
                if (lat_cnt_d == LAT_LAST) begin
                    ctrl_d.ir_we  = 1'b1;
                    ctrl_d.pc_we  = 1'b1;
                    ctrl_d.pc_src = PC_SRC_INC;
                end
            end
            ST_EXEC: begin
                ctrl_d.alu_b_imm = 1'b1;
                ctrl_d.alu_op    = alu_op_of(opcode);
                ctrl_d.flags_we  = is_alu_imm(opcode);
            end
            ST_MEM_RD: begin
                ctrl_d.addr_sel = ADDR_SEL_ALU;
                ctrl_d.mem_rd   = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_d.addr_sel = ADDR_SEL_ALU;
                ctrl_d.mem_we   = 1'b1;
            end
            ST_WB: begin
                ctrl_d.reg_we = 1'b1;
                ctrl_d.wb_sel = (opcode == OP_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
            end
            ST_BRANCH: begin
                ctrl_d.pc_src = PC_SRC_BRANCH;
                ctrl_d.pc_we  = (opcode == OP_BR) || ((opcode == OP_BZ) && zero);
            end
            default: ;
        endcase
    end

    // Sequencer state, latency counter, retire count and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            retired_q <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            retired_q <= retired_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // Write strobes are masked by rst so an aborted instruction commits nothing
    assign pc_we     = ctrl_q.pc_we & ~rst;
    assign ir_we     = ctrl_q.ir_we & ~rst;
    assign mem_we    = ctrl_q.mem_we & ~rst;
    assign reg_we    = ctrl_q.reg_we & ~rst;
    assign flags_we  = ctrl_q.flags_we & ~rst;
    assign pc_src    = ctrl_q.pc_src;
    assign addr_sel  = ctrl_q.addr_sel;
    assign mem_rd    = ctrl_q.mem_rd;
    assign wb_sel    = ctrl_q.wb_sel;
    assign alu_op    = ctrl_q.alu_op;
    assign alu_b_imm = ctrl_q.alu_b_imm;

    // PC must be cleared in the start cycle itself so the first fetch reads address 0
    assign pc_clr    = start & at_rest & ~rst;
    assign ext_grant = at_rest;
    assign busy      = ~at_rest;
    assign err       = (state_q == ST_ERR);
    assign retired   = retired_q;

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 32-bit single-memory CPU datapath (PC, IR, 32x32 register file, ALU with zero/n/v/c flags, one shared 32-word memory port).
- Drives all datapath strobes and muxes per instruction phase.
- Arbitrates the memory port between the external program loader (while idle) and the CPU (while running).
- Sits inside the CPU top beside the datapath; decodes only IR[31:26] and the flags.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (1..4); FETCH and MEM_RD hold for this many cycles.
- MAX_INSTR, 0, instruction budget; 0 = unlimited, else stop to IDLE after this many retired instructions.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins execution at PC=0
- ext_memwe  in  1  loader write request (memwe from top level)
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag (registered in datapath)
- ext_grant  out  1  memory port owned by loader
- pc_clr  out  1  PC <= 0
- pc_we  out  1  PC update
- pc_src  out  1  0: PC+1, 1: PC+sext(IR[25:0])
- ir_we  out  1  IR <= mem_rdata
- addr_sel  out  1  0: PC, 1: ALU result as memory address
- mem_rd  out  1  CPU read cycle
- mem_we  out  1  CPU store write
- reg_we  out  1  register-file write to rd = IR[25:21]
- wb_sel  out  1  0: ALU, 1: memory data
- alu_op  out  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR
- alu_b_imm  out  1  ALU B = sext(IR[15:0])
- flags_we  out  1  latch zero/n/v/c
- busy  out  1  not IDLE/ERR
- err  out  1  illegal opcode trap
- retired  out  16  retired-instruction count

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, lat_cnt=0, retired=0. All strobes 0, busy=0, err=0, ext_grant=1. Reset mid-instruction aborts immediately with no write that cycle.
- States: IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, BRANCH, ERR. Outputs are a Moore decode of state, plus lat_cnt in FETCH/MEM_RD.
- IDLE: ext_grant=1. start=1 -> pc_clr=1, retired<=0, next FETCH. start and ext_memwe together: start wins; the loader write in that same cycle is still performed (grant is combinational from state=IDLE).
- FETCH: addr_sel=0, mem_rd=1; hold MEM_LAT cycles. On the last cycle ir_we=1, pc_we=1, pc_src=0 -> DECODE.
- DECODE (1 cycle), dispatch on opcode:
  - 000001 ANDI, 000010 ORI, 000011 XORI, 000101 ADDI, 000110 SUBI -> EXEC
  - 001000 LOAD, 001001 STORE -> EXEC
  - 001100 BR, 001101 BZ -> BRANCH
  - 111111 HALT -> IDLE (retired+1)
  - any other opcode -> ERR
- EXEC: alu_b_imm=1.
  - ALU-immediate ops: alu_op per opcode, flags_we=1 -> WB.
  - LOAD/STORE: alu_op=ADD (rs+imm), flags_we=0 -> MEM_RD / MEM_WR.
- MEM_RD: addr_sel=1, mem_rd=1, MEM_LAT cycles -> WB.
- MEM_WR: addr_sel=1, mem_we=1, one cycle -> FETCH.
- WB: reg_we=1, wb_sel = (LOAD) -> FETCH.
- BRANCH: pc_we = (BR) or (BZ and zero), pc_src=1 -> FETCH. The offset is relative to the already-incremented PC.
- retired increments on the cycle that leaves WB, MEM_WR, BRANCH or HALT-DECODE; wraps 0xFFFF->0.
- If MAX_INSTR!=0 and the increment makes retired==MAX_INSTR, next state is IDLE instead of FETCH.
- While busy: ext_grant=0 and ext_memwe is ignored (no write). start is ignored.
- ERR: err=1, busy=0, ext_grant=1; leave only by rst or start (start clears err and restarts at FETCH with pc_clr).
- Cycles per instruction (MEM_LAT=1): ALU 4, LOAD 5, STORE 4, BR/BZ 3, HALT 2.

Decomposition:
- Package cpu_pkg: opcode constants (OP_ANDI..OP_HALT), ALU op encodings, state enum, pc_src/addr_sel/wb_sel encodings.
- Shared by datapath and bench.
- No sub-module needed; the latency counter stays inline.

Test Plan:
- Reset/idle: rst pulse -> ext_grant=1, busy=0, all strobes 0. Loader writes at addr 0..5 and 16 are accepted during IDLE.
- ALU path: ANDI 0x04005555 after start -> FETCH, DECODE, EXEC (alu_op=000, flags_we), WB (reg_we, wb_sel=0). Exactly 4 cycles; retired=1.
- Load/store: LOAD 0x201F0010 then STORE 0x241F0011 -> MEM_RD addr_sel=1, wb_sel=1; MEM_WR mem_we=1 for exactly one cycle.
- Branch: BR 0x33FFFFFB -> pc_we with pc_src=1 in BRANCH. BZ with zero=0 -> pc_we=0 in BRANCH. Loop with MAX_INSTR=12 stops in IDLE with retired=12.
- Illegal/halt: opcode 0x3E -> ERR, err=1, ext_grant=1; a later start clears err. Opcode 0x3F -> IDLE after 2 cycles.
- Arbitration/reset: ext_memwe during busy -> ext_grant=0, no write. rst asserted in MEM_RD with MEM_LAT=3 -> IDLE next cycle, mem_rd=0.
